// File: rtl/knn_feeder.sv
// Streams n_points (x,label) pairs from memory into the KNN register file, then reads INFO back.
// Latency per point: 5 bus transactions plus one idle cycle after each, plus one NEXT cycle.
// Backpressure: every request waits on m_ready; optional KNN_FEEDER_TIMEOUT_EN watchdog aborts a stalled one.
module knn_feeder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 16,
    parameter logic [ADDR_W-1:0] A_OFF      = 'h0,
    parameter logic [ADDR_W-1:0] LABEL_OFF  = 'h8,
    parameter logic [ADDR_W-1:0] ENABLE_OFF = 'hC,
    parameter logic [ADDR_W-1:0] INFO_OFF   = 'h10
`ifdef KNN_FEEDER_TIMEOUT_EN
    ,
    parameter int                TIMEOUT    = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   knn_base,
    input  logic [CNT_W-1:0]    n_points,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DATA_W-1:0]   info,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_X, S_RD_LBL, S_WR_A, S_WR_LBL, S_WR_EN, S_NEXT, S_RD_INFO, S_DONE
    } state_t;

    state_t              state_q;
    logic                busy_q, done_q, m_valid_q;
    logic [DATA_W-1:0]   info_q, m_wdata_q, x_q, lbl_q;
    logic [ADDR_W-1:0]   m_addr_q, ptr_q, knn_q;
    logic [DATA_W/8-1:0] m_wstrb_q;
    logic [CNT_W-1:0]    n_q, i_q;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    state_t              bus_nxt;

`ifdef KNN_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Request contents and successor state for whichever bus state is active.
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        bus_nxt   = S_IDLE;
        case (state_q)
            S_RD_X:    begin req_addr = ptr_q;                bus_nxt = S_RD_LBL; end
            S_RD_LBL:  begin req_addr = ptr_q + ADDR_W'(4);   bus_nxt = S_WR_A;   end
            S_WR_A:    begin req_addr = knn_q + A_OFF;      req_wdata = x_q;
                             req_wstrb = '1;                  bus_nxt = S_WR_LBL; end
            S_WR_LBL:  begin req_addr = knn_q + LABEL_OFF;  req_wdata = lbl_q;
                             req_wstrb = '1;                  bus_nxt = S_WR_EN;  end
            S_WR_EN:   begin req_addr = knn_q + ENABLE_OFF; req_wdata = DATA_W'(1);
                             req_wstrb = '1;                  bus_nxt = S_NEXT;   end
            S_RD_INFO: begin req_addr = knn_q + INFO_OFF;     bus_nxt = S_DONE;   end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            info_q    <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            x_q       <= '0;
            lbl_q     <= '0;
            ptr_q     <= '0;
            knn_q     <= '0;
            n_q       <= '0;
            i_q       <= '0;
`ifdef KNN_FEEDER_TIMEOUT_EN
            tmo_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_NEXT: begin
                    if (i_q == n_q - CNT_W'(1)) begin
                        state_q <= S_RD_INFO;
                    end else begin
                        i_q     <= i_q + CNT_W'(1);
                        ptr_q   <= ptr_q + ADDR_W'(8);
                        state_q <= S_RD_X;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    // Issue with m_valid low, retire on m_ready; the retire cycle leaves one idle gap.
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= req_addr;
                        m_wdata_q <= req_wdata;
                        m_wstrb_q <= req_wstrb;
`ifdef KNN_FEEDER_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (state_q == S_RD_X)    x_q    <= m_rdata;
                        if (state_q == S_RD_LBL)  lbl_q  <= m_rdata;
                        if (state_q == S_RD_INFO) info_q <= m_rdata;
                        state_q <= bus_nxt;
                        if (bus_nxt == S_DONE) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
`ifdef KNN_FEEDER_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        m_valid_q <= 1'b0;
                        error_q   <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
            endcase

            // DONE is a non-busy state, so a start landing there is accepted too.
            if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
                ptr_q <= src_base;
                knn_q <= knn_base;
                n_q   <= n_points;
                i_q   <= '0;
`ifdef KNN_FEEDER_TIMEOUT_EN
                error_q <= 1'b0;
`endif
                if (n_points == '0) begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    busy_q  <= 1'b1;
                    state_q <= S_RD_X;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign info    = info_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_knn_feeder.sv
// Directed bench for knn_feeder: memory/KNN target model with programmable ready delay and stalls.
module tb_knn_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_base, knn_base;
    logic [15:0] n_points;
    logic        busy, done, error;
    logic [31:0] info;
    logic        m_valid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;

    knn_feeder #(
`ifdef KNN_FEEDER_TIMEOUT_EN
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .knn_base(knn_base),
        .n_points(n_points), .busy(busy), .done(done), .error(error), .info(info),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] info_val = 32'h0;
    int          max_delay = 0;
    bit          never_ready = 1'b0;
    bit          stall_wr = 1'b0;

    logic [31:0] log_addr[$], log_data[$];
    logic [3:0]  log_strb[$];
    logic [31:0] ex_addr[$], ex_data[$];
    logic [3:0]  ex_strb[$];

    int done_cnt = 0;
    int valid_cycles = 0;

    always @(negedge clk) begin
        if (done === 1'b1)    done_cnt++;
        if (m_valid === 1'b1) valid_cycles++;
    end

    // Target: answers each request after a random 0..max_delay wait with a 1-cycle m_ready.
    initial begin : responder
        bit seen;
        int cnt, target;
        seen = 1'b0; cnt = 0; target = 0;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || m_ready) begin
                m_ready = 1'b0;
                seen    = 1'b0;
            end else if (m_valid === 1'b1 && !never_ready && !(stall_wr && m_wstrb != 4'h0)) begin
                if (!seen) begin
                    seen   = 1'b1;
                    cnt    = 0;
                    target = $urandom_range(0, max_delay);
                end
                if (cnt >= target) begin
                    log_addr.push_back(m_addr);
                    log_strb.push_back(m_wstrb);
                    log_data.push_back(m_wstrb != 4'h0 ? m_wdata : 32'h0);
                    m_rdata = mem.exists(m_addr) ? mem[m_addr] : info_val;
                    m_ready = 1'b1;
                    seen    = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ex_addr.push_back(a); ex_data.push_back(d); ex_strb.push_back(s);
    endtask

    // Two points {5,1},{9,0} at 'h1000 fed to KNN at 'h8000.
    task automatic load_exp_basic();
        ex_addr.delete(); ex_data.delete(); ex_strb.delete();
        exp_push(32'h1000, 32'h0, 4'h0);
        exp_push(32'h1004, 32'h0, 4'h0);
        exp_push(32'h8000, 32'h5, 4'hF);
        exp_push(32'h8008, 32'h1, 4'hF);
        exp_push(32'h800C, 32'h1, 4'hF);
        exp_push(32'h1008, 32'h0, 4'h0);
        exp_push(32'h100C, 32'h0, 4'h0);
        exp_push(32'h8000, 32'h9, 4'hF);
        exp_push(32'h8008, 32'h0, 4'hF);
        exp_push(32'h800C, 32'h1, 4'hF);
        exp_push(32'h8010, 32'h0, 4'h0);
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_strb.delete();
    endtask

    task automatic check_log(input string tag);
        checks++;
        if (log_addr.size() !== ex_addr.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d transactions, want %0d", tag, log_addr.size(), ex_addr.size());
        end
        for (int i = 0; i < ex_addr.size(); i++) begin
            checks++;
            if (i >= log_addr.size()) begin
                errors++;
                $display("FAIL %s[%0d]: missing, want addr %h data %h strb %h", tag, i, ex_addr[i], ex_data[i], ex_strb[i]);
            end else if (log_addr[i] !== ex_addr[i] || log_data[i] !== ex_data[i] || log_strb[i] !== ex_strb[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got addr %h data %h strb %h, want addr %h data %h strb %h", tag, i,
                         log_addr[i], log_data[i], log_strb[i], ex_addr[i], ex_data[i], ex_strb[i]);
            end
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] k, input logic [15:0] n);
        @(negedge clk);
        src_base = s; knn_base = k; n_points = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done: got no done within %0d cycles, want a done pulse", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; src_base = '0; knn_base = '0; n_points = '0;
        #2;
        checks++;
        if ({busy, done, error, m_valid, m_wstrb} !== 8'h0) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 00000000", {busy, done, error, m_valid, m_wstrb});
        end
        checks++;
        if (info !== 32'h0) begin errors++; $display("FAIL reset_info: got %h, want 0", info); end
        checks++;
        if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, want 0", m_addr); end
        checks++;
        if (m_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h, want 0", m_wdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        valid_cycles = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (valid_cycles !== 0) begin
            errors++; $display("FAIL reset_idle_valid: got %0d valid cycles, want 0", valid_cycles);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, want 0", busy); end
    endtask

    task automatic run_basic(input string tag, input logic [31:0] want_info);
        clear_log();
        load_exp_basic();
        done_cnt = 0;
        do_start(32'h1000, 32'h8000, 16'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b, want 1", tag, busy); end
        wait_done(400, tag);
        checks++;
        if (info !== want_info) begin errors++; $display("FAIL %s_info: got %h, want %h", tag, info, want_info); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b, want 0", tag, busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count: got %0d, want 1", tag, done_cnt); end
        check_log(tag);
    endtask

    task automatic test_stream();
        mem[32'h1000] = 32'd5; mem[32'h1004] = 32'd1;
        mem[32'h1008] = 32'd9; mem[32'h100C] = 32'd0;
        info_val  = 32'h1234_5678;
        max_delay = 0;
        run_basic("stream", 32'h1234_5678);
    endtask

    task automatic test_random_delay();
        info_val  = 32'hABCD_0003;
        max_delay = 7;
        run_basic("rand_delay", 32'hABCD_0003);
    endtask

    task automatic test_zero_and_busy();
        max_delay = 2;
        valid_cycles = 0;
        done_cnt = 0;
        @(negedge clk);
        src_base = 32'h1000; knn_base = 32'h8000; n_points = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b, want 0", done); end
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cycles !== 0) begin errors++; $display("FAIL zero_no_bus: got %0d valid cycles, want 0", valid_cycles); end
        checks++;
        if (info !== 32'hABCD_0003) begin errors++; $display("FAIL zero_info: got %h, want abcd0003", info); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d, want 1", done_cnt); end

        clear_log();
        load_exp_basic();
        done_cnt = 0;
        do_start(32'h1000, 32'h8000, 16'd2);
        repeat (3) @(negedge clk);
        src_base = 32'h2000; knn_base = 32'h9000; n_points = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, "busy_start");
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d, want 1", done_cnt); end
        check_log("busy_start");
    endtask

    task automatic test_reset_mid();
        bit found;
        max_delay = 0;
        stall_wr  = 1'b1;
        clear_log();
        do_start(32'h1000, 32'h8000, 16'd2);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_wstrb === 4'hF) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || m_addr !== 32'h8000) begin
            errors++; $display("FAIL mid_reach_wr_a: got found=%b addr %h, want found=1 addr 00008000", found, m_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_clear: got m_valid=%b busy=%b, want 0 0", m_valid, busy);
        end
        checks++;
        if (info !== 32'h0) begin errors++; $display("FAIL mid_reset_info: got %h, want 0", info); end
        stall_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        info_val = 32'h0000_0042;
        run_basic("mid_restart", 32'h0000_0042);
    endtask

`ifdef KNN_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        never_ready  = 1'b1;
        done_cnt     = 0;
        do_start(32'h1000, 32'h8000, 16'd1);
        valid_cycles = 0;
        wait_done(200, "timeout");
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b, want 1", error); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b, want 0", m_valid); end
        checks++;
        if (valid_cycles !== 16) begin
            errors++; $display("FAIL timeout_cycles: got %0d valid cycles, want 16", valid_cycles);
        end
        checks++;
        if (info !== 32'h0000_0042) begin errors++; $display("FAIL timeout_info: got %h, want 00000042", info); end
        never_ready = 1'b0;
        do_start(32'h1000, 32'h8000, 16'd1);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, want 0", error); end
        wait_done(400, "timeout_recover");
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_random_delay();
        test_zero_and_busy();
        test_reset_mid();
`ifdef KNN_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by 400000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
